inv_shift_rows_stream: RTL and testbench



---
 rtl/inv_shift_rows_stream.sv | 175 +++++++++++++++++
 tb/tb_inv_shift_rows_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_stream.sv
// inv_shift_rows_stream
//
// Byte-serial AES InvShiftRows engine. A 128-bit state arrives as 16 bytes
// in column-major order (byte 0 = state[127:120], byte b sits at row b%4,
// column b/4). Each block is written into one of two ping-pong banks and
// read back in permuted order, so one byte per cycle flows in both
// directions once the pipeline is primed.
//
// Inverse mapping: out byte k (r=k%4, c=k/4) <- in byte 4*((c-r)%4)+r.
// Forward mapping: out byte k                 <- in byte 4*((c+r)%4)+r.
//
// Optional feature macro: SHIFT_ROWS_FWD_EN
//   defined   -> 'dir' port exists; dir is captured with byte 0 of every
//                input block (1 = forward ShiftRows, 0 = inverse) and kept
//                per bank.
//   undefined -> no dir port, inverse mapping only.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input byte valid
//   in_ready   a byte can be accepted this cycle
//   in_data    input byte
//   out_valid  output byte valid
//   out_ready  downstream accepts the byte
//   out_data   output byte, 0 while out_valid is low
//   out_last   marks the 16th byte of each output block
//   dir        (SHIFT_ROWS_FWD_EN only) mapping select for the block

// One 16-byte bank: storage, full flag and (optionally) the block's dir.
module isr_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic       set_full,
  input  logic       clr_full,
  input  logic [3:0] raddr,
  output logic [7:0] rdata,
  output logic       full
`ifdef SHIFT_ROWS_FWD_EN
  ,
  input  logic       dir_we,
  input  logic       dir_in,
  output logic       dir
`endif
);
  logic [15:0][7:0] mem;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Set and clear never hit the same bank on one edge: the writer only
  // targets a bank that is not full, the reader only drains a full one.
  always_ff @(posedge clk) begin
    if (rst)           full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
  end

`ifdef SHIFT_ROWS_FWD_EN
  always_ff @(posedge clk) begin
    if (rst)         dir <= 1'b0;
    else if (dir_we) dir <= dir_in;
  end
`endif

  assign rdata = mem[raddr];
endmodule

module inv_shift_rows_stream (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
`ifdef SHIFT_ROWS_FWD_EN
  ,
  input  logic       dir
`endif
);
  localparam int NUM_BANKS = 2;

  logic                           wr_bank, rd_bank;
  logic [3:0]                     wr_cnt, rd_cnt;
  logic [NUM_BANKS-1:0]           full;
  logic [NUM_BANKS-1:0][7:0]      rdata;
  logic [NUM_BANKS-1:0]           bank_dir;
  logic                           wr_fire, rd_fire;
  logic                           rd_fwd;
  logic [3:0]                     rd_addr;

  // Source index inside the bank for output position k. Row/column are
  // 2-bit fields, so the mod-4 rotation is just 2-bit wrap-around.
  function automatic logic [3:0] perm(input logic [3:0] k, input logic fwd);
    logic [1:0] r, c, sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = fwd ? (c + r) : (c - r);
    return {sc, r};
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid & in_ready;
  assign rd_fire   = out_valid & out_ready;

`ifdef SHIFT_ROWS_FWD_EN
  assign rd_fwd = bank_dir[rd_bank];
`else
  assign bank_dir = '0;
  assign rd_fwd   = bank_dir[rd_bank];
`endif

  assign rd_addr  = perm(rd_cnt, rd_fwd);
  assign out_data = out_valid ? rdata[rd_bank] : 8'h00;
  assign out_last = out_valid & (rd_cnt == 4'd15);

  genvar g;
  generate
    for (g = 0; g < NUM_BANKS; g++) begin : g_bank
      logic wsel, rsel;
      assign wsel = wr_fire & (wr_bank == 1'(g));
      assign rsel = rd_fire & (rd_bank == 1'(g));

      isr_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (wsel),
        .waddr    (wr_cnt),
        .wdata    (in_data),
        .set_full (wsel & (wr_cnt == 4'd15)),
        .clr_full (rsel & (rd_cnt == 4'd15)),
        .raddr    (rd_addr),
        .rdata    (rdata[g]),
        .full     (full[g])
`ifdef SHIFT_ROWS_FWD_EN
        ,
        .dir_we   (wsel & (wr_cnt == 4'd0)),
        .dir_in   (dir),
        .dir      (bank_dir[g])
`endif
      );
    end
  endgenerate

  // Write side: counter wraps 15->0 on its own; bank flips with the last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= 4'd0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_cnt == 4'd15) wr_bank <= ~wr_bank;
    end
  end

  // Read side mirrors the write side, so blocks leave in arrival order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= 4'd0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (rd_cnt == 4'd15) rd_bank <= ~rd_bank;
    end
  end
endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Self-checking bench for inv_shift_rows_stream: directed block tests plus
// randomized traffic, checked against a row-rotation reference model.
module tb_inv_shift_rows_stream;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
`ifdef SHIFT_ROWS_FWD_EN
  logic       dir;
`endif

  inv_shift_rows_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef SHIFT_ROWS_FWD_EN
    ,
    .dir       (dir)
`endif
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A block is viewed as a 4x4 matrix st[row][col]; row r is rotated right
  // by r (inverse) or left by r (forward), then read back column-major.
  function automatic logic [15:0][7:0] ref_perm(input logic [15:0][7:0] blk, input logic fwd);
    logic [7:0] st [4][4];
    logic [7:0] o  [4][4];
    logic [15:0][7:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = blk[4*c+r];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (fwd) o[r][c] = st[r][(c+r)%4];
        else     o[r][(c+r)%4] = st[r][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[4*c+r] = o[r][c];
    return res;
  endfunction

  logic [8:0]       expq [$];   // {last, byte}
  logic [7:0]       obs  [$];   // bytes observed leaving the DUT
  logic [15:0][7:0] cur;
  int               cur_n = 0;
  logic             cur_dir = 1'b0;
  int               pend = 0;   // completed blocks not yet fully drained
  bit               armed = 0;
  int               or_mode = 1; // 0: out_ready low, 1: high, 2: random

  // Monitor: sample at negedge, predict what the next rising edge does.
  initial begin
    logic [15:0][7:0] pb;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("in_ready", in_ready, pend < 2);
        chk("out_valid", out_valid, pend > 0);
        if (out_valid) begin
          if (expq.size() == 0) chk("exp_empty", expq.size(), 1);
          else begin
            chk("out_data", out_data, expq[0][7:0]);
            chk("out_last", out_last, expq[0][8]);
          end
        end else begin
          chk("idle_data", out_data, 0);
          chk("idle_last", out_last, 0);
        end
      end
      if (rst) begin
        expq.delete(); cur_n = 0; pend = 0; armed = 1;
      end else if (armed) begin
        if (out_valid && out_ready && expq.size() > 0) begin
          e = expq.pop_front();
          obs.push_back(out_data);
          if (e[8]) pend--;
        end
        if (in_valid && in_ready) begin
`ifdef SHIFT_ROWS_FWD_EN
          if (cur_n == 0) cur_dir = dir;
`endif
          cur[cur_n] = in_data;
          cur_n++;
          if (cur_n == 16) begin
            pb = ref_perm(cur, cur_dir);
            for (int k = 0; k < 16; k++) expq.push_back({k == 15, pb[k]});
            pend++;
            cur_n = 0;
          end
        end
      end
    end
  end

  // out_ready driver, updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic push_byte(input logic [7:0] d);
    bit ok;
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; t++;
    end while (!ok && t < 2000);
    chk("in_timeout", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_blk(input logic [15:0][7:0] blk, input int maxgap, input logic fwd);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
`ifdef SHIFT_ROWS_FWD_EN
      dir = (i == 0) ? fwd : 1'($urandom);
`else
      if (fwd) $display("note: dir ignored without SHIFT_ROWS_FWD_EN");
`endif
      push_byte(blk[i]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((expq.size() != 0 || pend != 0) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_timeout", expq.size(), 0);
  endtask

  task automatic cmp_obs(input string tag, input logic [15:0][7:0] ref_seq);
    chk({tag, "_len"}, obs.size(), 16);
    for (int i = 0; i < 16 && i < obs.size(); i++) chk(tag, obs[i], ref_seq[i]);
  endtask

  function automatic logic [15:0][7:0] rand_blk();
    logic [15:0][7:0] b;
    for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    return b;
  endfunction

  // ---------------- test sequence ----------------
  logic [15:0][7:0] seq, inv_exp, fwd_exp;
  logic [7:0]       d0;

  initial begin
    for (int i = 0; i < 16; i++) seq[i] = 8'(i);
    inv_exp = {8'h03,8'h06,8'h09,8'h0C,8'h0F,8'h02,8'h05,8'h08,
               8'h0B,8'h0E,8'h01,8'h04,8'h07,8'h0A,8'h0D,8'h00};
    fwd_exp = {8'h0B,8'h06,8'h01,8'h0C,8'h07,8'h02,8'h0D,8'h08,
               8'h03,8'h0E,8'h09,8'h04,8'h0F,8'h0A,8'h05,8'h00};
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
`ifdef SHIFT_ROWS_FWD_EN
    dir = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(posedge clk); #1;

    // single block, inverse
    obs.delete();
    send_blk(seq, 0, 1'b0);
    chk("lat_valid", out_valid, 1);
    chk("lat_first", out_data, 8'h00);
    wait_idle();
    cmp_obs("single", inv_exp);

    // back-to-back, three blocks
    or_mode = 1;
    for (int b = 0; b < 3; b++) send_blk(rand_blk(), 0, 1'b0);
    wait_idle();

    // backpressure: two blocks queued with out_ready low
    or_mode = 0;
    @(posedge clk); #1;
    send_blk(rand_blk(), 0, 1'b0);
    send_blk(rand_blk(), 0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    d0 = out_data;
    repeat (5) @(negedge clk);
    chk("bp_hold", out_data, d0);
    chk("bp_hold_valid", out_valid, 1);
    @(posedge clk); #1;
    or_mode = 1;
    wait_idle();

    // random gaps on both sides
    or_mode = 2;
    for (int b = 0; b < 100; b++) send_blk(rand_blk(), 2, 1'b0);
    wait_idle();
    or_mode = 1;

    // reset with block 1 half drained and 7 bytes of block 2 buffered
    or_mode = 0;
    @(posedge clk); #1;
    send_blk(rand_blk(), 0, 1'b0);
    for (int i = 0; i < 7; i++) push_byte(8'($urandom));
    or_mode = 1;
    repeat (9) @(posedge clk);
    #1 or_mode = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    or_mode = 1;
    obs.delete();
    send_blk(seq, 0, 1'b0);
    wait_idle();
    cmp_obs("post_rst", inv_exp);

`ifdef SHIFT_ROWS_FWD_EN
    obs.delete();
    send_blk(seq, 0, 1'b1);
    wait_idle();
    cmp_obs("fwd", fwd_exp);
    obs.delete();
    send_blk(seq, 0, 1'b0);
    wait_idle();
    cmp_obs("fwd_inv", inv_exp);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
